// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end, 2-entry output buffer, optional FETCH_PERF_EN counters
`ifndef HBIT_ADDR
`define HBIT_ADDR 9
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module fetch_stage #(
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  output logic [`HBIT_ADDR:0] ow_mem_addr,
  output logic                ow_mem_we,
  input  logic [`HBIT_DATA:0] iw_mem_rdata,
  input  logic                iw_redirect,
  input  logic [`HBIT_ADDR:0] iw_redirect_pc,
  output logic                or_valid,
  input  logic                iw_ready,
  output logic [`HBIT_DATA:0] or_instr,
  output logic [`HBIT_ADDR:0] or_instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         or_fetch_cnt,
  output logic [31:0]         or_stall_cnt
`endif
);

  localparam logic [`HBIT_ADDR:0] RESET_ADDR = RESET_PC[`HBIT_ADDR:0];

  if (FIFO_DEPTH != 2) begin : g_bad_depth
    $error("fetch_stage: FIFO_DEPTH must be 2");
  end

  // Fetch pointer and the single outstanding memory request
  logic [`HBIT_ADDR:0] r_pc;
  logic [`HBIT_ADDR:0] r_issue_pc;
  logic                r_inflight;

  // Second buffer entry; the head entry lives directly in the output registers
  logic                r_skid_valid;
  logic [`HBIT_DATA:0] r_skid_instr;
  logic [`HBIT_ADDR:0] r_skid_pc;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ;
  logic [2:0] credit_used;
  logic [2:0] credit_limit;

  assign ow_mem_addr = r_pc;
  assign ow_mem_we   = 1'b0;

  // Handshake terms and credit check: never request more than the buffer can absorb
  always_comb begin
    pop          = or_valid & iw_ready;
    push         = r_inflight & ~iw_redirect;
    occ          = {1'b0, or_valid} + {1'b0, r_skid_valid};
    credit_used  = {1'b0, occ} + {2'b0, r_inflight};
    credit_limit = 3'd2 + {2'b0, pop};
    issue        = ~iw_redirect & (credit_used < credit_limit);
  end

  // Fetch address sequencing; a redirect suppresses the issue and reloads the pointer
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_pc       <= RESET_ADDR;
      r_issue_pc <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= issue;
      if (iw_redirect) begin
        r_pc <= iw_redirect_pc;
      end else if (issue) begin
        r_pc       <= r_pc + 1'b1;
        r_issue_pc <= r_pc;
      end
    end
  end

  // Two-entry buffer: head in output registers, second entry behind it; data holds when emptied
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      or_valid     <= 1'b0;
      or_instr     <= '0;
      or_instr_pc  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (iw_redirect) begin
      or_valid     <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (pop) begin
      if (r_skid_valid) begin
        or_instr    <= r_skid_instr;
        or_instr_pc <= r_skid_pc;
        if (push) begin
          r_skid_instr <= iw_mem_rdata;
          r_skid_pc    <= r_issue_pc;
        end else begin
          r_skid_valid <= 1'b0;
        end
      end else if (push) begin
        or_instr    <= iw_mem_rdata;
        or_instr_pc <= r_issue_pc;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (push) begin
      if (or_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= iw_mem_rdata;
        r_skid_pc    <= r_issue_pc;
      end else begin
        or_valid    <= 1'b1;
        or_instr    <= iw_mem_rdata;
        or_instr_pc <= r_issue_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-word and downstream-stall counters; they survive redirects
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      or_fetch_cnt <= '0;
      or_stall_cnt <= '0;
    end else begin
      if (pop) begin
        or_fetch_cnt <= or_fetch_cnt + 32'd1;
      end
      if (or_valid & ~iw_ready) begin
        or_stall_cnt <= or_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a queue-based reference model
`ifndef HBIT_ADDR
`define HBIT_ADDR 9
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module tb_fetch_stage;
  localparam int AW        = `HBIT_ADDR + 1;
  localparam int DW        = `HBIT_DATA + 1;
  localparam int RESET_PC  = 0;
  localparam int MEM_WORDS = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          valid;
  logic          ready = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]   fetch_cnt;
  logic [31:0]   stall_cnt;
`endif

  logic [DW-1:0] mem [MEM_WORDS];

  // reference model state
  ent_t          mq[$];
  logic [AW-1:0] inq[$];
  logic [AW-1:0] m_pc = AW'(RESET_PC);
  ent_t          m_last = '0;
  logic [31:0]   m_pops = 0;
  logic [31:0]   m_stalls = 0;

  int total = 0;
  int bad = 0;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .iw_clk         (clk),
    .iw_rst         (rst),
    .ow_mem_addr    (mem_addr),
    .ow_mem_we      (mem_we),
    .iw_mem_rdata   (mem_rdata),
    .iw_redirect    (redirect),
    .iw_redirect_pc (redirect_pc),
    .or_valid       (valid),
    .iw_ready       (ready),
    .or_instr       (instr),
    .or_instr_pc    (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .or_fetch_cnt   (fetch_cnt),
    .or_stall_cnt   (stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  // synchronous instruction memory, one-cycle read latency
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one clock of the reference model: in-order buffer of at most two words, one request in flight
  task automatic model_step();
    bit            do_pop;
    bit            do_issue;
    bit            have_ret;
    int            used;
    logic [AW-1:0] ret_pc;
    ent_t          e;
    ret_pc = '0;
    if (rst) begin
      mq.delete();
      inq.delete();
      m_pc = AW'(RESET_PC);
      m_last = '0;
      m_pops = 0;
      m_stalls = 0;
      return;
    end
    do_pop = (mq.size() != 0) && (ready == 1'b1);
    if (mq.size() != 0 && ready == 1'b0) m_stalls++;
    used = mq.size() + inq.size() - (do_pop ? 1 : 0);
    do_issue = (redirect == 1'b0) && (used < 2);
    have_ret = inq.size() != 0;
    if (have_ret) ret_pc = inq.pop_front();
    if (do_pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (redirect) begin
      mq.delete();
    end else if (have_ret) begin
      e.instr = mem[ret_pc];
      e.pc = ret_pc;
      mq.push_back(e);
    end
    if (do_issue) inq.push_back(m_pc);
    if (redirect) m_pc = redirect_pc;
    else if (do_issue) m_pc = m_pc + 1'b1;
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = AW'(5);
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total += 5;
      if (valid !== 1'b0) begin bad++; $display("FAIL reset valid cyc=%0d got=%b exp=0", c, valid); end
      if (instr !== '0) begin bad++; $display("FAIL reset instr cyc=%0d got=%h exp=0", c, instr); end
      if (instr_pc !== '0) begin bad++; $display("FAIL reset instr_pc cyc=%0d got=%h exp=0", c, instr_pc); end
      if (mem_addr !== AW'(RESET_PC)) begin bad++; $display("FAIL reset mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, AW'(RESET_PC)); end
      if (mem_we !== 1'b0) begin bad++; $display("FAIL reset mem_we cyc=%0d got=%b exp=0", c, mem_we); end
    end
`ifdef FETCH_PERF_EN
    total += 2;
    if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL reset fetch_cnt got=%0d exp=0", fetch_cnt); end
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    redirect = 1'b0;
  endtask

  task automatic test_stream();
    rst = 1'b0;
    ready = 1'b1;
    redirect = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total += 5;
      if (valid !== (mq.size() != 0)) begin bad++; $display("FAIL stream valid cyc=%0d got=%b exp=%b", c, valid, mq.size() != 0); end
      if (instr !== m_last.instr) begin bad++; $display("FAIL stream instr cyc=%0d got=%h exp=%h", c, instr, m_last.instr); end
      if (instr_pc !== m_last.pc) begin bad++; $display("FAIL stream instr_pc cyc=%0d got=%h exp=%h", c, instr_pc, m_last.pc); end
      if (mem_addr !== m_pc) begin bad++; $display("FAIL stream mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, m_pc); end
      if (valid !== (c >= 2)) begin bad++; $display("FAIL stream first_valid cyc=%0d got=%b exp=%b", c, valid, c >= 2); end
      if (c >= 2 && c <= 5) begin
        total += 2;
        if (instr !== mem[AW'(c - 2)]) begin bad++; $display("FAIL stream word cyc=%0d got=%h exp=%h", c, instr, mem[AW'(c - 2)]); end
        if (instr_pc !== AW'(c - 2)) begin bad++; $display("FAIL stream word_pc cyc=%0d got=%h exp=%h", c, instr_pc, AW'(c - 2)); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] exp_next;
    exp_next = (mq.size() != 0) ? mq[0].pc : m_pc;
    for (int c = 0; c < 17; c++) begin
      ready = (c < 5) ? 1'b0 : 1'b1;
      total += 4;
      if (valid !== (mq.size() != 0)) begin bad++; $display("FAIL bp valid cyc=%0d got=%b exp=%b", c, valid, mq.size() != 0); end
      if (instr !== m_last.instr) begin bad++; $display("FAIL bp instr cyc=%0d got=%h exp=%h", c, instr, m_last.instr); end
      if (instr_pc !== m_last.pc) begin bad++; $display("FAIL bp instr_pc cyc=%0d got=%h exp=%h", c, instr_pc, m_last.pc); end
      if (mem_addr !== m_pc) begin bad++; $display("FAIL bp mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, m_pc); end
      if (mq.size() != 0 && ready == 1'b1) begin
        total += 2;
        if (instr_pc !== exp_next) begin bad++; $display("FAIL bp order cyc=%0d got=%h exp=%h", c, instr_pc, exp_next); end
        if (instr !== mem[exp_next]) begin bad++; $display("FAIL bp order_word cyc=%0d got=%h exp=%h", c, instr, mem[exp_next]); end
        exp_next = exp_next + 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [AW-1:0] tgt;
    int            guard;
    for (int t = 0; t < 3; t++) begin
      tgt = (t == 0) ? AW'(256) : (t == 1) ? AW'(512) : AW'(MEM_WORDS - 1);
      ready = (t == 0) ? 1'b0 : 1'b1;
      guard = 0;
      while (((t == 0) ? (mq.size() != 2) : (guard < 4)) && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        total++;
        bad++;
        $display("FAIL redirect fill_timeout target=%h got_occ=%0d exp_occ=2", tgt, mq.size());
      end
      redirect = 1'b1;
      redirect_pc = tgt;
      ready = 1'b1;
      tick();
      redirect = 1'b0;
      for (int k = 1; k <= 7; k++) begin
        total += 4;
        if (valid !== (mq.size() != 0)) begin bad++; $display("FAIL redir valid k=%0d got=%b exp=%b", k, valid, mq.size() != 0); end
        if (instr !== m_last.instr) begin bad++; $display("FAIL redir instr k=%0d got=%h exp=%h", k, instr, m_last.instr); end
        if (instr_pc !== m_last.pc) begin bad++; $display("FAIL redir instr_pc k=%0d got=%h exp=%h", k, instr_pc, m_last.pc); end
        if (mem_addr !== m_pc) begin bad++; $display("FAIL redir mem_addr k=%0d got=%h exp=%h", k, mem_addr, m_pc); end
        total++;
        if (valid !== (k >= 3)) begin bad++; $display("FAIL redir bubble k=%0d got=%b exp=%b", k, valid, k >= 3); end
        if (valid === 1'b1) begin
          total += 2;
          if (instr_pc !== tgt + AW'(k - 3)) begin bad++; $display("FAIL redir new_pc k=%0d got=%h exp=%h", k, instr_pc, tgt + AW'(k - 3)); end
          if (instr !== mem[tgt + AW'(k - 3)]) begin bad++; $display("FAIL redir new_word k=%0d got=%h exp=%h", k, instr, mem[tgt + AW'(k - 3)]); end
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_redirect();
    ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = AW'(85);
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    total += 2;
    if (valid !== 1'b0) begin bad++; $display("FAIL rstredir valid got=%b exp=0", valid); end
    if (mem_addr !== AW'(RESET_PC)) begin bad++; $display("FAIL rstredir mem_addr got=%h exp=%h", mem_addr, AW'(RESET_PC)); end
    for (int c = 0; c < 5; c++) begin
      total += 4;
      if (valid !== (mq.size() != 0)) begin bad++; $display("FAIL rstredir valid cyc=%0d got=%b exp=%b", c, valid, mq.size() != 0); end
      if (instr !== m_last.instr) begin bad++; $display("FAIL rstredir instr cyc=%0d got=%h exp=%h", c, instr, m_last.instr); end
      if (instr_pc !== m_last.pc) begin bad++; $display("FAIL rstredir instr_pc cyc=%0d got=%h exp=%h", c, instr_pc, m_last.pc); end
      if (mem_addr !== m_pc) begin bad++; $display("FAIL rstredir mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, m_pc); end
      if (c == 2) begin
        total += 2;
        if (valid !== 1'b1) begin bad++; $display("FAIL rstredir resume_valid got=%b exp=1", valid); end
        if (instr_pc !== AW'(RESET_PC)) begin bad++; $display("FAIL rstredir resume_pc got=%h exp=%h", instr_pc, AW'(RESET_PC)); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      redirect = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
      redirect_pc = AW'($urandom);
      rst = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
      total += 4;
      if (valid !== (mq.size() != 0)) begin bad++; $display("FAIL random valid cyc=%0d got=%b exp=%b", c, valid, mq.size() != 0); end
      if (instr !== m_last.instr) begin bad++; $display("FAIL random instr cyc=%0d got=%h exp=%h", c, instr, m_last.instr); end
      if (instr_pc !== m_last.pc) begin bad++; $display("FAIL random instr_pc cyc=%0d got=%h exp=%h", c, instr_pc, m_last.pc); end
      if (mem_addr !== m_pc) begin bad++; $display("FAIL random mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, m_pc); end
`ifdef FETCH_PERF_EN
      total += 2;
      if (fetch_cnt !== m_pops) begin bad++; $display("FAIL random fetch_cnt cyc=%0d got=%0d exp=%0d", c, fetch_cnt, m_pops); end
      if (stall_cnt !== m_stalls) begin bad++; $display("FAIL random stall_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, m_stalls); end
`endif
      tick();
    end
    rst = 1'b0;
    redirect = 1'b0;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int guard;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b1;
    guard = 0;
    while (m_pops < 5 && guard < 50) begin tick(); guard++; end
    ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    ready = 1'b1;
    while (m_pops < 10 && guard < 100) begin tick(); guard++; end
    ready = 1'b0;
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL perf pop_timeout got=%0d exp=10", m_pops);
    end
    total += 2;
    if (fetch_cnt !== 32'd10) begin bad++; $display("FAIL perf fetch_cnt got=%0d exp=10", fetch_cnt); end
    if (stall_cnt !== 32'd3) begin bad++; $display("FAIL perf stall_cnt got=%0d exp=3", stall_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = DW'($urandom);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_reset_redirect();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
